lsu_mem_ctrl: RTL and testbench
===============================

// Module: lsu_mem_ctrl
// PURPOSE
//  Parametrised sequential load/store unit. Sits between execute stage and data-memory port.
//  Accepts one load/store per valid/ready handshake and decodes funct3 into size and sign.
//  Drives a req/gnt/rvalid memory bus with word-aligned address, byte enables and lane-shifted write data.
//  Returns aligned, sign/zero-extended load data or a store ack; optionally splits word-crossing misaligned accesses into two beats.
// PARAMETERS
//  XLEN            32  data/bus width, 32 or 64; BYTES = XLEN/8
//  ADDR_W          32  address width
//  MISALIGN_SPLIT  1   1: misaligned accesses split into beats as needed; 0: any misaligned access faults
// PORTS
//  clk          in   1       clock, rising edge
//  rst_n        in   1       asynchronous active-low reset
//  req_valid    in   1       request valid
//  req_ready    out  1       request accepted when valid&ready; = (state==IDLE)
//  req_we       in   1       1 store, 0 load
//  req_funct3   in   3       RV funct3: B/H/W/D (000/001/010/011), BU/HU/WU (100/101/110)
//  req_addr     in   ADDR_W  byte address (aluout)
//  req_wdata    in   XLEN    store data, LSB-justified
//  mem_req      out  1       bus request, held until mem_gnt
//  mem_gnt      in   1       bus grant
//  mem_addr     out  ADDR_W  word-aligned address (low log2(BYTES) bits zero)
//  mem_we       out  1       write enable
//  mem_be       out  BYTES   byte enables
//  mem_wdata    out  XLEN    lane-shifted write data
//  mem_rvalid   in   1       beat response (load data or store ack)
//  mem_rdata    in   XLEN    read data
//  mem_err      in   1       bus error, qualified by mem_rvalid
//  rsp_valid    out  1       one-cycle response pulse, no backpressure
//  rsp_rdata    out  XLEN    extended load data; 0 for stores/faults
//  rsp_fault    out  2       00 ok, 01 misaligned, 10 bus error, 11 illegal funct3
// BEHAVIOUR
//  Reset: FSM IDLE; mem_req, mem_we, rsp_valid 0; mem_addr, mem_be, mem_wdata, rsp_rdata, rsp_fault 0.
//  req_valid ignored while rst_n low. All outputs except req_ready are registered.
//  FSM: IDLE -> BEAT0_REQ -> BEAT0_WAIT -> [BEAT1_REQ -> BEAT1_WAIT] -> RESP -> IDLE.
//  - IDLE: on accept, latch request, compute beat0. Illegal funct3 or (misaligned & !SPLIT) -> RESP, no bus access.
//    Illegal: funct3 111; store with funct3[2]=1; 011/110 when XLEN=32.
//  - *_REQ: mem_req=1 and addr/we/be/wdata stable until mem_gnt; on gnt drop mem_req, go to *_WAIT.
//  - *_WAIT: on mem_rvalid capture data. mem_err -> RESP with fault 10, remaining beat skipped.
//    Else, if split -> BEAT1_REQ, otherwise -> RESP.
//  - RESP: rsp_valid=1 for exactly one cycle, then IDLE. req_ready high again the same cycle.
//  mem_rvalid outside *_WAIT is ignored.
//  Latency (zero-wait bus, gnt same cycle as req, rvalid next cycle):
//    accept T, mem_req T+1, rvalid T+2, rsp_valid T+3.
//    Split adds 2 cycles. Fault without bus access: rsp_valid T+1.
//  Size s = 1<<funct3[1:0] bytes; off = addr[log2(BYTES)-1:0]; misaligned = off % s != 0.
//  Beat0 be = ((1<<s)-1)<<off truncated to BYTES; wdata0 = wdata<<(8*off).
//  Split needed iff off+s > BYTES. Beat1 at mem_addr+BYTES: be = (1<<(off+s-BYTES))-1, wdata1 = wdata>>(8*(BYTES-off)).
//  Load assembly: (rdata0>>(8*off)) | (rdata1<<(8*(BYTES-off))), masked to s bytes.
//  Then sign-extend if funct3[2]=0, else zero-extend, to XLEN.
//  Async reset mid-transaction: mem_req drops immediately, no rsp_valid; a late bus rvalid is ignored after reset.
// STRUCTURE
//  lsu_pkg: funct3 constants (F3_B..F3_WU), fault codes, FSM state enum, size/offset helper functions.
//  Sub-module lsu_align: combinational be/wdata lane shift, load merge and extension; instantiated once.
//  Top holds FSM, request latch, beat-0 data register, bus and response registers.
// TESTING (XLEN=32)
//  1. LW 0x1000, rdata 0xDEADBEEF, zero-wait bus -> mem_be 1111; rsp_valid T+3, rsp_rdata 0xDEADBEEF, fault 00.
//  2. LB 0x2003, rdata 0x80123456 -> be 1000, rsp_rdata 0xFFFFFF80; same with LBU -> 0x00000080.
//  3. SH 0x3001, wdata 0x0000BEEF, SPLIT=1 -> single beat, be 0110, mem_wdata 0x00BEEF00, rsp fault 00.
//  4. LW 0x1002, SPLIT=1, rdata0 0xAABBCCDD, rdata1 0x11223344 -> addr 0x1000 be 1100, then addr 0x1004 be 0011;
//     rsp_rdata 0x3344AABB at T+5.
//  5. SW 0x4001, SPLIT=0 -> no mem_req, rsp_valid T+1, fault 01. funct3 111 -> fault 11.
//  6. Split load with mem_err on beat0 -> no beat1 mem_req, fault 10.
//     rst_n low during BEAT0_WAIT -> mem_req/rsp_valid 0 immediately, req_ready 1 after release.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
//   - funct3 encodings for the RV load/store sizes
//   - fault codes returned on rsp_fault
//   - FSM state encoding used by lsu_mem_ctrl
//   - size / misalignment / legality helpers for funct3 decode
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    localparam logic [1:0] FLT_OK       = 2'b00;
    localparam logic [1:0] FLT_MISALIGN = 2'b01;
    localparam logic [1:0] FLT_BUS      = 2'b10;
    localparam logic [1:0] FLT_ILLEGAL  = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        BEAT0_REQ,
        BEAT0_WAIT,
        BEAT1_REQ,
        BEAT1_WAIT,
        RESP
    } lsu_state_e;

    // Access size in bytes: 1, 2, 4 or 8.
    function automatic logic [3:0] f3_size(input logic [2:0] f3);
        return 4'd1 << f3[1:0];
    endfunction

    // Byte offset not a multiple of the access size.
    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [3:0] off);
        return |(off & (f3_size(f3) - 4'd1));
    endfunction

    // Encodings with no meaning for this datapath width / direction.
    function automatic logic f3_illegal(input logic [2:0] f3, input logic we, input int xlen);
        logic ill;
        ill = (f3 == 3'b111) || (we && f3[2]);
        if (xlen == 32 && (f3 == F3_D || f3 == F3_WU))
            ill = 1'b1;
        return ill;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane alignment for the load/store unit.
//   funct3      in   access size and signedness
//   off         in   byte offset of the access within a bus word
//   wdata       in   LSB-justified store data
//   rdata0/1    in   read data of beat 0 / beat 1 (beat 1 zero when unused)
//   be0/be1     out  byte enables of beat 0 / beat 1
//   wdata0/1    out  lane-shifted store data of beat 0 / beat 1
//   split       out  access crosses into the next bus word
//   ldata       out  merged, sign/zero-extended load data
module lsu_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]               funct3,
    input  logic [$clog2(XLEN/8)-1:0] off,
    input  logic [XLEN-1:0]          wdata,
    input  logic [XLEN-1:0]          rdata0,
    input  logic [XLEN-1:0]          rdata1,
    output logic [XLEN/8-1:0]        be0,
    output logic [XLEN/8-1:0]        be1,
    output logic [XLEN-1:0]          wdata0,
    output logic [XLEN-1:0]          wdata1,
    output logic                     split,
    output logic [XLEN-1:0]          ldata
);

    localparam int BYTES = XLEN / 8;

    // Keep the low s bytes, then fill the rest with the top kept bit
    // (signed loads) or zero (unsigned loads).
    function automatic logic [XLEN-1:0] extend_load(input logic [XLEN-1:0] d,
                                                     input logic [3:0]      s,
                                                     input logic            is_unsigned);
        logic [XLEN-1:0] r;
        logic            sb;
        r  = '0;
        sb = 1'b0;
        for (int i = 0; i < BYTES; i++) begin
            if (i < int'(s)) begin
                r[8*i +: 8] = d[8*i +: 8];
                sb          = d[8*i + 7];
            end
        end
        sb = sb & ~is_unsigned;
        for (int i = 0; i < BYTES; i++) begin
            if (i >= int'(s))
                r[8*i +: 8] = {8{sb}};
        end
        return r;
    endfunction

    logic [3:0]          size;
    logic [BYTES-1:0]    mask;
    logic [2*BYTES-1:0]  be_win;
    logic [2*XLEN-1:0]   wd_win;
    logic [XLEN-1:0]     merged;

    // Two-word windows: the upper half of each window is what spills into beat 1.
    always_comb begin
        size = f3_size(funct3);
        mask = '0;
        for (int i = 0; i < BYTES; i++)
            mask[i] = (i < int'(size));
        be_win = {{BYTES{1'b0}}, mask} << off;
        wd_win = {{XLEN{1'b0}}, wdata} << {off, 3'b000};
        merged = XLEN'({rdata1, rdata0} >> {off, 3'b000});
    end

    assign be0    = be_win[BYTES-1:0];
    assign be1    = be_win[2*BYTES-1:BYTES];
    assign wdata0 = wd_win[XLEN-1:0];
    assign wdata1 = wd_win[2*XLEN-1:XLEN];
    assign split  = |be_win[2*BYTES-1:BYTES];
    assign ldata  = extend_load(merged, size, funct3[2]);

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Sequential load/store unit between the execute stage and a req/gnt/rvalid
// data-memory port. One request per valid/ready handshake; misaligned accesses
// that cross a bus word are split into two beats when MISALIGN_SPLIT=1.
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready   request handshake (ready only in IDLE)
//   req_we, req_funct3    direction and RV size/sign encoding
//   req_addr, req_wdata   byte address, LSB-justified store data
//   mem_req/mem_gnt       bus request held until grant
//   mem_addr/we/be/wdata  word-aligned bus beat
//   mem_rvalid/rdata/err  beat response
//   rsp_valid/rdata/fault one-cycle response pulse with extended data / fault code
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int ADDR_W         = 32,
    parameter int MISALIGN_SPLIT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              mem_req,
    input  logic              mem_gnt,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [XLEN/8-1:0] mem_be,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   mem_rdata,
    input  logic              mem_err,
    output logic              rsp_valid,
    output logic [XLEN-1:0]   rsp_rdata,
    output logic [1:0]        rsp_fault
);

    localparam int BYTES = XLEN / 8;
    localparam int OFF_W = $clog2(BYTES);

    lsu_state_e        state;

    // Request latch and beat-0 read data (data path, not reset)
    logic [2:0]        f3_q;
    logic              we_q;
    logic [OFF_W-1:0]  off_q;
    logic [XLEN-1:0]   wdata_q;
    logic              split_q;
    logic [XLEN-1:0]   rdata0_q;

    logic              idle;
    logic              accept;
    logic              req_illegal;
    logic              req_misal;

    logic [2:0]        al_f3;
    logic [OFF_W-1:0]  al_off;
    logic [XLEN-1:0]   al_wdata;
    logic [XLEN-1:0]   al_rd0;
    logic [XLEN-1:0]   al_rd1;
    logic [BYTES-1:0]  al_be0;
    logic [BYTES-1:0]  al_be1;
    logic [XLEN-1:0]   al_wd0;
    logic [XLEN-1:0]   al_wd1;
    logic              al_split;
    logic [XLEN-1:0]   al_ldata;

    assign idle        = (state == IDLE);
    assign req_ready   = idle;
    assign accept      = idle && req_valid;
    assign req_illegal = f3_illegal(req_funct3, req_we, XLEN);
    assign req_misal   = f3_misaligned(req_funct3, 4'(req_addr[OFF_W-1:0]));

    // The single aligner sees the live request while idle (beat-0 lanes are
    // registered on accept) and the latched request afterwards. In BEAT1_WAIT
    // the two read beats are merged; otherwise the live beat is beat 0 alone.
    always_comb begin
        al_f3    = idle ? req_funct3 : f3_q;
        al_off   = idle ? req_addr[OFF_W-1:0] : off_q;
        al_wdata = idle ? req_wdata : wdata_q;
        al_rd0   = (state == BEAT1_WAIT) ? rdata0_q : mem_rdata;
        al_rd1   = (state == BEAT1_WAIT) ? mem_rdata : '0;
    end

    lsu_align #(
        .XLEN (XLEN)
    ) u_align (
        .funct3 (al_f3),
        .off    (al_off),
        .wdata  (al_wdata),
        .rdata0 (al_rd0),
        .rdata1 (al_rd1),
        .be0    (al_be0),
        .be1    (al_be1),
        .wdata0 (al_wd0),
        .wdata1 (al_wd1),
        .split  (al_split),
        .ldata  (al_ldata)
    );

    // Request latch / beat-0 capture
    always_ff @(posedge clk) begin
        if (accept) begin
            f3_q    <= req_funct3;
            we_q    <= req_we;
            off_q   <= req_addr[OFF_W-1:0];
            wdata_q <= req_wdata;
            split_q <= al_split;
        end
        if (state == BEAT0_WAIT && mem_rvalid)
            rdata0_q <= mem_rdata;
    end

    // FSM, bus and response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_fault <= FLT_OK;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (req_illegal) begin
                            rsp_valid <= 1'b1;
                            rsp_rdata <= '0;
                            rsp_fault <= FLT_ILLEGAL;
                            state     <= RESP;
                        end else if (req_misal && MISALIGN_SPLIT == 0) begin
                            rsp_valid <= 1'b1;
                            rsp_rdata <= '0;
                            rsp_fault <= FLT_MISALIGN;
                            state     <= RESP;
                        end else begin
                            mem_req   <= 1'b1;
                            mem_we    <= req_we;
                            mem_addr  <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                            mem_be    <= al_be0;
                            mem_wdata <= al_wd0;
                            state     <= BEAT0_REQ;
                        end
                    end
                end
                BEAT0_REQ: begin
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        state   <= BEAT0_WAIT;
                    end
                end
                BEAT0_WAIT: begin
                    if (mem_rvalid) begin
                        if (mem_err) begin
                            rsp_valid <= 1'b1;
                            rsp_rdata <= '0;
                            rsp_fault <= FLT_BUS;
                            state     <= RESP;
                        end else if (split_q) begin
                            mem_req   <= 1'b1;
                            mem_addr  <= mem_addr + ADDR_W'(BYTES);
                            mem_be    <= al_be1;
                            mem_wdata <= al_wd1;
                            state     <= BEAT1_REQ;
                        end else begin
                            rsp_valid <= 1'b1;
                            rsp_rdata <= we_q ? '0 : al_ldata;
                            rsp_fault <= FLT_OK;
                            state     <= RESP;
                        end
                    end
                end
                BEAT1_REQ: begin
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        state   <= BEAT1_WAIT;
                    end
                end
                BEAT1_WAIT: begin
                    if (mem_rvalid) begin
                        rsp_valid <= 1'b1;
                        rsp_rdata <= (we_q || mem_err) ? '0 : al_ldata;
                        rsp_fault <= mem_err ? FLT_BUS : FLT_OK;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl (XLEN=32). dut1 splits misaligned
// accesses, dut0 faults them. A zero-wait bus model grants in the request
// cycle and answers one cycle later.
module tb_lsu_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        req_valid1, req_valid0, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        mem_gnt, mem_rvalid, mem_err;
    logic [31:0] mem_rdata;

    logic        req_ready1, mem_req1, mem_we1, rsp_valid1;
    logic [31:0] mem_addr1, mem_wdata1, rsp_rdata1;
    logic [3:0]  mem_be1;
    logic [1:0]  rsp_fault1;

    logic        req_ready0, mem_req0, mem_we0, rsp_valid0;
    logic [31:0] mem_addr0, mem_wdata0, rsp_rdata0;
    logic [3:0]  mem_be0;
    logic [1:0]  rsp_fault0;

    lsu_mem_ctrl #(.XLEN(32), .ADDR_W(32), .MISALIGN_SPLIT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid1), .req_ready(req_ready1),
        .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .mem_req(mem_req1), .mem_gnt(mem_gnt), .mem_addr(mem_addr1), .mem_we(mem_we1),
        .mem_be(mem_be1), .mem_wdata(mem_wdata1), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .mem_err(mem_err), .rsp_valid(rsp_valid1), .rsp_rdata(rsp_rdata1), .rsp_fault(rsp_fault1)
    );

    lsu_mem_ctrl #(.XLEN(32), .ADDR_W(32), .MISALIGN_SPLIT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid0), .req_ready(req_ready0),
        .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .mem_req(mem_req0), .mem_gnt(mem_gnt), .mem_addr(mem_addr0), .mem_we(mem_we0),
        .mem_be(mem_be0), .mem_wdata(mem_wdata0), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .mem_err(mem_err), .rsp_valid(rsp_valid0), .rsp_rdata(rsp_rdata0), .rsp_fault(rsp_fault0)
    );

    // Bus model (serves dut1)
    logic        gnt_en, bus_mute, late_pulse, bus_err0;
    logic [31:0] bus_addr0, bus_rd0, bus_rd1;

    assign mem_gnt = mem_req1 & gnt_en;

    always @(posedge clk) begin
        mem_rvalid <= (mem_req1 && mem_gnt && !bus_mute) || late_pulse;
        mem_rdata  <= (mem_addr1 == bus_addr0) ? bus_rd0 : bus_rd1;
        mem_err    <= (mem_addr1 == bus_addr0) ? bus_err0 : 1'b0;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Observations of the last transaction
    int          nbeats, req_k, rsp_k, rsp_cnt;
    logic [31:0] rsp_d;
    logic [1:0]  rsp_f;
    logic [31:0] b_addr [2];
    logic [31:0] b_wdata[2];
    logic [3:0]  b_be   [2];
    logic        b_we   [2];

    // Issue one request at the current negedge and observe 12 cycles.
    // k counts cycles after the accepting edge.
    task automatic txn(input bit use0, input bit we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] rd0, input logic [31:0] rd1, input bit err0);
        bus_rd0   = rd0;
        bus_rd1   = rd1;
        bus_err0  = err0;
        bus_addr0 = {addr[31:2], 2'b00};
        nbeats = 0; req_k = 0; rsp_k = 0; rsp_cnt = 0; rsp_d = '0; rsp_f = '0;
        req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        if (use0) req_valid0 = 1'b1;
        else      req_valid1 = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            req_valid0 = 1'b0;
            req_valid1 = 1'b0;
            if (use0 ? mem_req0 : mem_req1) begin
                if (req_k == 0) req_k = k;
                if (!use0 && mem_gnt && nbeats < 2) begin
                    b_addr[nbeats]  = mem_addr1;
                    b_be[nbeats]    = mem_be1;
                    b_wdata[nbeats] = mem_wdata1;
                    b_we[nbeats]    = mem_we1;
                    nbeats++;
                end
            end
            if (use0 ? rsp_valid0 : rsp_valid1) begin
                rsp_cnt++;
                if (rsp_k == 0) begin
                    rsp_k = k;
                    rsp_d = use0 ? rsp_rdata0 : rsp_rdata1;
                    rsp_f = use0 ? rsp_fault0 : rsp_fault1;
                end
            end
        end
    endtask

    int cnt;

    initial begin
        req_valid1 = 0; req_valid0 = 0; req_we = 0; req_funct3 = '0;
        req_addr = '0; req_wdata = '0;
        gnt_en = 1; bus_mute = 0; late_pulse = 0; bus_err0 = 0;
        bus_addr0 = '0; bus_rd0 = '0; bus_rd1 = '0;

        // Reset: requests ignored, outputs cleared
        repeat (2) @(negedge clk);
        req_valid1 = 1'b1;
        req_addr   = 32'h1000;
        req_funct3 = 3'b010;
        @(negedge clk);
        check_eq("rst_ignores_req", 32'(mem_req1), 32'd0);
        req_valid1 = 1'b0;
        rst_n      = 1'b1;
        @(negedge clk);
        check_eq("rst_ready",  32'(req_ready1), 32'd1);
        check_eq("rst_memreq", 32'(mem_req1),   32'd0);
        check_eq("rst_memwe",  32'(mem_we1),    32'd0);
        check_eq("rst_rspv",   32'(rsp_valid1), 32'd0);
        check_eq("rst_addr",   mem_addr1,       32'd0);
        check_eq("rst_be",     32'(mem_be1),    32'd0);
        check_eq("rst_wdata",  mem_wdata1,      32'd0);
        check_eq("rst_rdata",  rsp_rdata1,      32'd0);
        check_eq("rst_fault",  32'(rsp_fault1), 32'd0);

        // 1. LW aligned
        txn(0, 0, 3'b010, 32'h1000, 32'h0, 32'hDEADBEEF, 32'h0, 0);
        check_eq("lw_req_k",  32'(req_k),    32'd1);
        check_eq("lw_beats",  32'(nbeats),   32'd1);
        check_eq("lw_addr",   b_addr[0],     32'h1000);
        check_eq("lw_be",     32'(b_be[0]),  32'hF);
        check_eq("lw_we",     32'(b_we[0]),  32'd0);
        check_eq("lw_rsp_k",  32'(rsp_k),    32'd3);
        check_eq("lw_rspcnt", 32'(rsp_cnt),  32'd1);
        check_eq("lw_rdata",  rsp_d,         32'hDEADBEEF);
        check_eq("lw_fault",  32'(rsp_f),    32'd0);

        // 2. LB / LBU at byte 3
        txn(0, 0, 3'b000, 32'h2003, 32'h0, 32'h80123456, 32'h0, 0);
        check_eq("lb_addr",  b_addr[0],    32'h2000);
        check_eq("lb_be",    32'(b_be[0]), 32'h8);
        check_eq("lb_rdata", rsp_d,        32'hFFFFFF80);
        txn(0, 0, 3'b100, 32'h2003, 32'h0, 32'h80123456, 32'h0, 0);
        check_eq("lbu_rdata", rsp_d,       32'h00000080);
        // LH / LHU on upper half
        txn(0, 0, 3'b001, 32'h2002, 32'h0, 32'h80123456, 32'h0, 0);
        check_eq("lh_be",     32'(b_be[0]), 32'hC);
        check_eq("lh_rdata",  rsp_d,        32'hFFFF8012);
        txn(0, 0, 3'b101, 32'h2002, 32'h0, 32'h80123456, 32'h0, 0);
        check_eq("lhu_rdata", rsp_d,        32'h00008012);

        // 3. SH misaligned within the word -> single beat
        txn(0, 1, 3'b001, 32'h3001, 32'h0000BEEF, 32'h0, 32'h0, 0);
        check_eq("sh_beats", 32'(nbeats),   32'd1);
        check_eq("sh_addr",  b_addr[0],     32'h3000);
        check_eq("sh_be",    32'(b_be[0]),  32'h6);
        check_eq("sh_wdata", b_wdata[0],    32'h00BEEF00);
        check_eq("sh_we",    32'(b_we[0]),  32'd1);
        check_eq("sh_rsp_k", 32'(rsp_k),    32'd3);
        check_eq("sh_fault", 32'(rsp_f),    32'd0);
        check_eq("sh_rdata", rsp_d,         32'd0);

        // 4. LW crossing a word -> two beats
        txn(0, 0, 3'b010, 32'h1002, 32'h0, 32'hAABBCCDD, 32'h11223344, 0);
        check_eq("lws_beats", 32'(nbeats),  32'd2);
        check_eq("lws_addr0", b_addr[0],    32'h1000);
        check_eq("lws_be0",   32'(b_be[0]), 32'hC);
        check_eq("lws_addr1", b_addr[1],    32'h1004);
        check_eq("lws_be1",   32'(b_be[1]), 32'h3);
        check_eq("lws_rsp_k", 32'(rsp_k),   32'd5);
        check_eq("lws_rdata", rsp_d,        32'h3344AABB);
        check_eq("lws_fault", 32'(rsp_f),   32'd0);

        // SW crossing a word -> two beats with shifted data
        txn(0, 1, 3'b010, 32'h1003, 32'h11223344, 32'h0, 32'h0, 0);
        check_eq("sws_beats", 32'(nbeats),   32'd2);
        check_eq("sws_be0",   32'(b_be[0]),  32'h8);
        check_eq("sws_wd0",   b_wdata[0],    32'h44000000);
        check_eq("sws_be1",   32'(b_be[1]),  32'h7);
        check_eq("sws_wd1",   b_wdata[1],    32'h00112233);
        check_eq("sws_rsp_k", 32'(rsp_k),    32'd5);

        // 5. Faults without bus access
        txn(1, 1, 3'b010, 32'h4001, 32'h12345678, 32'h0, 32'h0, 0);
        check_eq("mis_noreq", 32'(req_k),   32'd0);
        check_eq("mis_rsp_k", 32'(rsp_k),   32'd1);
        check_eq("mis_fault", 32'(rsp_f),   32'd1);
        check_eq("mis_cnt",   32'(rsp_cnt), 32'd1);
        txn(0, 0, 3'b111, 32'h1000, 32'h0, 32'h0, 32'h0, 0);
        check_eq("f7_noreq",  32'(req_k),   32'd0);
        check_eq("f7_rsp_k",  32'(rsp_k),   32'd1);
        check_eq("f7_fault",  32'(rsp_f),   32'd3);
        txn(0, 1, 3'b100, 32'h1000, 32'h0, 32'h0, 32'h0, 0);
        check_eq("sbu_fault", 32'(rsp_f),   32'd3);
        txn(0, 0, 3'b011, 32'h1000, 32'h0, 32'h0, 32'h0, 0);
        check_eq("ld32_fault", 32'(rsp_f),  32'd3);
        check_eq("ld32_noreq", 32'(req_k),  32'd0);

        // 6. Bus error on beat 0 of a split load
        txn(0, 0, 3'b010, 32'h1002, 32'h0, 32'hAABBCCDD, 32'h11223344, 1);
        check_eq("err_beats", 32'(nbeats), 32'd1);
        check_eq("err_rsp_k", 32'(rsp_k),  32'd3);
        check_eq("err_fault", 32'(rsp_f),  32'd2);
        check_eq("err_rdata", rsp_d,       32'd0);

        // Reset while the request waits for grant
        gnt_en = 0;
        req_we = 0; req_funct3 = 3'b010; req_addr = 32'h1000;
        req_valid1 = 1'b1;
        @(negedge clk);
        req_valid1 = 1'b0;
        @(negedge clk);
        check_eq("hold_req",  32'(mem_req1), 32'd1);
        check_eq("hold_addr", mem_addr1,     32'h1000);
        rst_n = 1'b0;
        #1;
        check_eq("rstreq_drop", 32'(mem_req1), 32'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        gnt_en = 1;

        // Reset in BEAT0_WAIT, then a late rvalid
        bus_mute  = 1;
        bus_addr0 = 32'h1000;
        req_valid1 = 1'b1;
        @(negedge clk);
        req_valid1 = 1'b0;
        @(negedge clk);
        check_eq("wait_be", 32'(mem_be1), 32'hF);
        rst_n = 1'b0;
        #1;
        check_eq("rstw_req",  32'(mem_req1),   32'd0);
        check_eq("rstw_rspv", 32'(rsp_valid1), 32'd0);
        check_eq("rstw_be",   32'(mem_be1),    32'd0);
        @(negedge clk);
        rst_n      = 1'b1;
        bus_mute   = 0;
        late_pulse = 1;
        @(negedge clk);
        late_pulse = 0;
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (rsp_valid1) cnt++;
        end
        check_eq("late_rvalid_ignored", 32'(cnt),        32'd0);
        check_eq("ready_after_rst",     32'(req_ready1), 32'd1);

        // Recovery after reset
        txn(0, 0, 3'b010, 32'h1000, 32'h0, 32'h12345678, 32'h0, 0);
        check_eq("rec_rsp_k", 32'(rsp_k), 32'd3);
        check_eq("rec_rdata", rsp_d,      32'h12345678);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
